// File: rtl/uart_word_tx_fifo_pkg.sv
// Shared UART definitions: baud divider constants, transmitter FSM states and
// the Baud_Set to clocks-per-bit mapping (also used by the receive side).
package uart_word_tx_fifo_pkg;

    localparam logic [12:0] BPS_9600   = 13'd5208;
    localparam logic [12:0] BPS_19200  = 13'd2604;
    localparam logic [12:0] BPS_38400  = 13'd1302;
    localparam logic [12:0] BPS_57600  = 13'd868;
    localparam logic [12:0] BPS_115200 = 13'd434;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_e;

    // Unused selector codes fall back to the fastest rate.
    function automatic logic [12:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd0:    return BPS_9600;
            3'd1:    return BPS_19200;
            3'd2:    return BPS_38400;
            3'd3:    return BPS_57600;
            default: return BPS_115200;
        endcase
    endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO; an extra wrap bit on each pointer separates full from empty.
module uart_word_fifo
    import uart_word_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_word_tx_fifo.sv
// Buffered word UART transmitter: queues DATA_WIDTH-bit words and sends each
// as consecutive 8N1 bytes, byte order chosen by MSB_FIRST.
module uart_word_tx_fifo
    import uart_word_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MSB_FIRST  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic [2:0]                    Baud_Set,
    output logic                          uart_tx,
    output logic                          Tx_Done,
    output logic                          uart_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(NBYTES - 1);

    tx_state_e             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [12:0]           bps;
    logic [12:0]           bit_cnt;
    logic [3:0]            bit_idx;
    logic [BIW-1:0]        byte_idx;
    logic [7:0]            cur_byte;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    assign fifo_push  = data_valid & ~fifo_full;
    assign fifo_pop   = (state == LOAD);
    assign data_ready = ~fifo_full;

    uart_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (data_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // The byte on the line always sits at the outgoing end of the shift register.
    assign cur_byte = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1 -: 8] : shreg[7:0];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            uart_tx    <= 1'b1;
            Tx_Done    <= 1'b0;
            uart_state <= 1'b0;
            shreg      <= '0;
            bps        <= BPS_115200;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
        end else begin
            Tx_Done <= 1'b0;
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    shreg      <= fifo_rdata;
                    bps        <= baud_div(Baud_Set);
                    bit_cnt    <= '0;
                    bit_idx    <= '0;
                    byte_idx   <= '0;
                    uart_state <= 1'b1;
                    uart_tx    <= 1'b0;
                    state      <= START;
                end
                START, DATA, STOP: begin
                    if (bit_cnt == bps - 13'd1) begin
                        bit_cnt <= '0;
                        // bit_idx: 0 start, 1..8 data, 9 stop
                        if (bit_idx == 4'd9) begin
                            bit_idx <= '0;
                            if (byte_idx != LAST_BYTE) begin
                                byte_idx <= byte_idx + 1'b1;
                                shreg    <= (MSB_FIRST != 0) ? (shreg << 8) : (shreg >> 8);
                                uart_tx  <= 1'b0;
                                state    <= START;
                            end else begin
                                Tx_Done    <= 1'b1;
                                uart_state <= 1'b0;
                                uart_tx    <= 1'b1;
                                state      <= IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 4'd8) begin
                                uart_tx <= 1'b1;
                                state   <= STOP;
                            end else begin
                                uart_tx <= cur_byte[bit_idx[2:0]];
                                state   <= DATA;
                            end
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx_fifo.sv
// Directed bench for uart_word_tx_fifo: two 16-bit instances (MSB-first and
// LSB-first) share stimulus; line decoders check bytes against a scoreboard.
module tb_uart_word_tx_fifo;

    localparam int DW        = 16;
    localparam int BPS_FAST  = 434;
    localparam int BPS_SLOW  = 5208;
    localparam int WORD_FAST = 10 * 2 * BPS_FAST;

    typedef struct {
        logic [7:0] b;
        int         bps;
    } exp_t;

    logic          Clk;
    logic          Rst;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic [2:0]    Baud_Set;
    logic          ready0, tx0, done0, state0;
    logic          ready1, tx1, done1, state1;
    logic [2:0]    level0, level1;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_assert  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int fall_cnt  = 0;
    int last_fall = 0;
    int rise_cnt  = 0;
    int last_rise = 0;
    int done_cnt  = 0;
    int last_done = 0;
    int done_cnt1 = 0;
    int push_cyc  = 0;
    int d0        = 0;
    logic prev_tx = 1'b1;
    logic prev_st = 1'b0;

    logic [15:0] bw [6]      = '{16'h2468, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    int          exp_lvl [6] = '{1, 2, 2, 3, 4, 4};
    int          exp_rdy [6] = '{1, 1, 1, 1, 0, 0};

    uart_word_tx_fifo #(
        .DATA_WIDTH (DW),
        .MSB_FIRST  (1),
        .FIFO_DEPTH (4)
    ) dut_msb (
        .Clk        (Clk),
        .Rst        (Rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (ready0),
        .Baud_Set   (Baud_Set),
        .uart_tx    (tx0),
        .Tx_Done    (done0),
        .uart_state (state0),
        .fifo_level (level0)
    );

    uart_word_tx_fifo #(
        .DATA_WIDTH (DW),
        .MSB_FIRST  (0),
        .FIFO_DEPTH (4)
    ) dut_lsb (
        .Clk        (Clk),
        .Rst        (Rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (ready1),
        .Baud_Set   (Baud_Set),
        .uart_tx    (tx1),
        .Tx_Done    (done1),
        .uart_state (state1),
        .fifo_level (level1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Event log for the MSB-first instance, sampled on the falling edge.
    always @(negedge Clk) begin
        prev_tx <= tx0;
        prev_st <= state0;
        if (prev_tx === 1'b1 && tx0 === 1'b0 && prev_st === 1'b0) begin
            fall_cnt  <= fall_cnt + 1;
            last_fall <= cyc;
        end
        if (prev_tx === 1'b0 && tx0 === 1'b1) begin
            rise_cnt  <= rise_cnt + 1;
            last_rise <= cyc;
        end
        if (done0 === 1'b1) begin
            done_cnt  <= done_cnt + 1;
            last_done <= cyc;
        end
        if (done1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input int which);
        return (which == 0) ? tx0 : tx1;
    endfunction

    task automatic push_word(input logic [15:0] w, input bit accept, input int bps);
        exp_t e;
        data_in    = w;
        data_valid = 1'b1;
        if (accept) begin
            e.bps = bps;
            e.b = w[15:8]; sb0.push_back(e);
            e.b = w[7:0];  sb0.push_back(e);
            e.b = w[7:0];  sb1.push_back(e);
            e.b = w[15:8]; sb1.push_back(e);
        end
        @(negedge Clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int s = done_cnt;
        int k = 0;
        while (done_cnt == s && k < limit) begin
            @(negedge Clk);
            k++;
        end
        check(tag, 32'(done_cnt != s), 32'd1);
    endtask

    task automatic wait_fall(input string tag, input int limit);
        int s = fall_cnt;
        int k = 0;
        while (fall_cnt == s && k < limit) begin
            @(negedge Clk);
            k++;
        end
        check(tag, 32'(fall_cnt != s), 32'd1);
    endtask

    task automatic wait_rise(input string tag, input int limit);
        int s = rise_cnt;
        int k = 0;
        while (rise_cnt == s && k < limit) begin
            @(negedge Clk);
            k++;
        end
        check(tag, 32'(rise_cnt != s), 32'd1);
    endtask

    task automatic mon_wait(input int n, inout bit ab);
        for (int k = 0; k < n && !ab; k++) begin
            @(negedge Clk);
            if (Rst) ab = 1'b1;
        end
    endtask

    task automatic monitor(input int which);
        exp_t       e;
        logic [9:0] frame;
        bit         ab;
        forever begin
            @(negedge Clk);
            while (line(which) !== 1'b0 || Rst) @(negedge Clk);
            if ((which == 0 ? sb0.size() : sb1.size()) == 0) begin
                check($sformatf("m%0d_unexpected_frame", which), 32'd0, 32'd1);
                e.b   = 8'h00;
                e.bps = BPS_FAST;
            end else begin
                e = (which == 0) ? sb0.pop_front() : sb1.pop_front();
            end
            ab    = 1'b0;
            frame = '0;
            mon_wait(e.bps / 2, ab);
            frame[0] = line(which);
            for (int b = 1; b < 10 && !ab; b++) begin
                mon_wait(e.bps, ab);
                frame[b] = line(which);
            end
            if (!ab) check($sformatf("m%0d_frame_%02h", which, e.b), 32'(frame), 32'({1'b1, e.b, 1'b0}));
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        Rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        Baud_Set   = 3'd4;
        repeat (3) @(negedge Clk);
        check("rst_tx0",    32'(tx0),    32'd1);
        check("rst_done0",  32'(done0),  32'd0);
        check("rst_state0", 32'(state0), 32'd0);
        check("rst_ready0", 32'(ready0), 32'd1);
        check("rst_level0", 32'(level0), 32'd0);
        check("rst_tx1",    32'(tx1),    32'd1);
        check("rst_done1",  32'(done1),  32'd0);
        check("rst_state1", 32'(state1), 32'd0);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_level1", 32'(level1), 32'd0);
        Rst = 1'b0;

        // Burst of six pushes on consecutive cycles; the sixth meets a full FIFO.
        for (int i = 0; i < 6; i++) begin
            push_word(bw[i], i < 5, BPS_FAST);
            if (i == 0) push_cyc = cyc;
            check($sformatf("burst_level0_%0d", i), 32'(level0), 32'(exp_lvl[i]));
            check($sformatf("burst_ready0_%0d", i), 32'(ready0), 32'(exp_rdy[i]));
            check($sformatf("burst_level1_%0d", i), 32'(level1), 32'(exp_lvl[i]));
            check($sformatf("burst_ready1_%0d", i), 32'(ready1), 32'(exp_rdy[i]));
        end
        wait_done("w0_done_seen", WORD_FAST + 100);
        check("w0_fall_latency", 32'(last_fall - push_cyc), 32'd2);
        check("w0_duration",     32'(last_done - last_fall), 32'(WORD_FAST));
        for (int k = 1; k < 5; k++) begin
            wait_fall($sformatf("w%0d_fall_seen", k), 10);
            check($sformatf("w%0d_gap", k),   32'(last_fall - last_done), 32'd2);
            check($sformatf("w%0d_level", k), 32'(level0), 32'(4 - k));
            wait_done($sformatf("w%0d_done_seen", k), WORD_FAST + 100);
            check($sformatf("w%0d_duration", k), 32'(last_done - last_fall), 32'(WORD_FAST));
        end
        check("burst_end_level", 32'(level0), 32'd0);
        check("burst_end_ready", 32'(ready0), 32'd1);

        // Push then push-with-pop at level 1; baud change while A is on the line.
        @(negedge Clk);
        push_word(16'hC3A1, 1'b1, BPS_FAST);
        push_cyc = cyc;
        check("pp_level_push", 32'(level0), 32'd1);
        @(negedge Clk);
        check("pp_level_load", 32'(level0), 32'd1);
        push_word(16'h3355, 1'b1, BPS_SLOW);
        check("pp_level_pushpop", 32'(level0), 32'd1);
        repeat (1000) @(negedge Clk);
        Baud_Set = 3'd0;
        wait_done("a_done_seen", WORD_FAST + 100);
        check("a_fall_latency", 32'(last_fall - push_cyc), 32'd2);
        check("a_duration",     32'(last_done - last_fall), 32'(WORD_FAST));
        wait_fall("b_fall_seen", 10);
        check("b_gap", 32'(last_fall - last_done), 32'd2);
        push_word(16'h0F0F, 1'b1, BPS_SLOW);
        check("c_level", 32'(level0), 32'd1);
        wait_rise("b_rise_seen", BPS_SLOW + 100);
        check("b_start_bit", 32'(last_rise - last_fall), 32'(BPS_SLOW));

        // Reset inside B's first data bit.
        repeat (2000) @(negedge Clk);
        d0  = done_cnt;
        Rst = 1'b1;
        @(negedge Clk);
        check("midrst_tx0",    32'(tx0),    32'd1);
        check("midrst_tx1",    32'(tx1),    32'd1);
        check("midrst_state0", 32'(state0), 32'd0);
        check("midrst_level0", 32'(level0), 32'd0);
        check("midrst_ready0", 32'(ready0), 32'd1);
        check("midrst_done0",  32'(done0),  32'd0);
        @(negedge Clk);
        Rst      = 1'b0;
        Baud_Set = 3'd4;
        sb0.delete();
        sb1.delete();
        repeat (20) @(negedge Clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_idle_tx", 32'(tx0), 32'd1);

        push_word(16'hA5A5, 1'b1, BPS_FAST);
        push_cyc = cyc;
        wait_done("f_done_seen", WORD_FAST + 100);
        check("f_fall_latency", 32'(last_fall - push_cyc), 32'd2);
        check("f_duration",     32'(last_done - last_fall), 32'(WORD_FAST));
        repeat (50) @(negedge Clk);
        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        check("done_count0", 32'(done_cnt),  32'd7);
        check("done_count1", 32'(done_cnt1), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
